// File: rtl/conv_pkg.sv
// Shared types and width helpers for the convolution window controller.
// Contents:
//   win_state_t  - controller state encoding
//   cnt_w()      - counter width for a dimension (at least 1 bit)
//   DEF_*        - default geometry (28x28 image, 5x5 window)
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } win_state_t;

  localparam int unsigned DEF_IMG_W = 28;
  localparam int unsigned DEF_IMG_H = 28;
  localparam int unsigned DEF_K     = 5;

  // Bits needed to count 0..n-1, never less than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rc_counter.sv
// 2-D raster row/col counter.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   inc       - advance one position (col first, row on col wrap)
//   row, col  - current position
//   last_c    - combinational: position is (ROWS-1, COLS-1)
// The counter wraps to (0,0) after the last position.
module rc_counter
  import conv_pkg::*;
#(
  parameter  int unsigned COLS = DEF_IMG_W,
  parameter  int unsigned ROWS = DEF_IMG_H,
  localparam int unsigned CW   = cnt_w(COLS),
  localparam int unsigned RW   = cnt_w(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last_c
);

  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic          col_last;
  logic          row_last;

  assign col_last = (col_q == CW'(COLS - 1));
  assign row_last = (row_q == RW'(ROWS - 1));
  assign last_c   = col_last & row_last;
  assign row      = row_q;
  assign col      = col_q;

  // Next position: column wraps into the next row, last row wraps to 0.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (inc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Frame sequencer for the KxK line-buffer window feeding the MAC array.
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   start                 - begin a frame (only honoured in IDLE)
//   in_valid / in_ready   - pixel source handshake (in_ready combinational)
//   buf_en                - line buffer / window register shift enable (= accept)
//   win_valid / win_ready - window handshake toward the MAC array
//   win_row, win_col      - top-left coordinate of the presented window
//   busy                  - controller is not IDLE
//   frame_done            - one-cycle pulse once the last window is consumed
module conv_window_ctrl
  import conv_pkg::*;
#(
  parameter  int unsigned IMG_W = DEF_IMG_W,
  parameter  int unsigned IMG_H = DEF_IMG_H,
  parameter  int unsigned K     = DEF_K,
  localparam int unsigned CW    = cnt_w(IMG_W),
  localparam int unsigned RW    = cnt_w(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          buf_en,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          busy,
  output logic          frame_done
);

  win_state_t    state_q, state_d;
  logic          win_valid_q, win_valid_d;
  logic [RW-1:0] win_row_q, win_row_d;
  logic [CW-1:0] win_col_q, win_col_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic          accept;
  logic          qualify;
  logic          last_px;
  logic [RW-1:0] r;
  logic [CW-1:0] c;

  // A pending unconsumed window stalls the source and freezes the buffers.
  assign in_ready = (state_q == RUN) & (~win_valid_q | win_ready);
  assign accept   = in_valid & in_ready;
  assign buf_en   = accept;

  // Column gate also excludes windows that would straddle two rows.
  assign qualify  = accept & (r >= RW'(K - 1)) & (c >= CW'(K - 1));

  rc_counter #(
    .COLS (IMG_W),
    .ROWS (IMG_H)
  ) u_rc (
    .clk    (clk),
    .rst    (rst),
    .inc    (accept),
    .row    (r),
    .col    (c),
    .last_c (last_px)
  );

  // Next state and registered output values.
  always_comb begin
    state_d     = state_q;
    win_valid_d = win_valid_q;
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;

    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (accept && last_px) state_d = DRAIN;
      DRAIN:   if (!win_valid_q || win_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // New window replaces a consumed one in the same cycle, without a bubble.
    if (qualify) begin
      win_valid_d = 1'b1;
      win_row_d   = r - RW'(K - 1);
      win_col_d   = c - CW'(K - 1);
    end else if (win_ready) begin
      win_valid_d = 1'b0;
    end

    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      win_valid_q  <= 1'b0;
      win_row_q    <= '0;
      win_col_q    <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_valid_q  <= win_valid_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign win_valid  = win_valid_q;
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
